// File: rtl/hpdmc_sched.sv
// hpdmc_sched: hands the SDRAM command bus to one of two requesters in round-robin
// order and inserts AUTO REFRESH slots, which take priority over any new grant.
module hpdmc_sched #(
  parameter int PEND_W = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sdram_initialized,
  input  logic [10:0] tim_refi,
  input  logic [3:0]  tim_rfc,
  input  logic        req0,
  input  logic        req1,
  input  logic        rel0,
  input  logic        rel1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ref_cmd,
  output logic        busy,
  output logic        ref_overrun
);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_GRANT0    = 3'd2,
    S_GRANT1    = 3'd3,
    S_REFRESH   = 3'd4,
    S_REF_WAIT  = 3'd5
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);
  localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(1'b0);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [3:0]        waitcnt_q, waitcnt_d;
  logic [10:0]       refcnt_q, refcnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              tick_s;
  logic              refresh_s;
  logic              gnt0_s, gnt1_s, ref_cmd_s, busy_s;
  logic              gnt0_q, gnt1_q, ref_cmd_q, busy_q;

  // FSM state, arbitration pointer, refresh wait counter and registered output decodes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_WAIT_INIT;
      last_q    <= 1'b1;
      waitcnt_q <= 4'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ref_cmd_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      waitcnt_q <= waitcnt_d;
      gnt0_q    <= gnt0_s;
      gnt1_q    <= gnt1_s;
      ref_cmd_q <= ref_cmd_s;
      busy_q    <= busy_s;
    end
  end

  // Refresh interval timer, pending-refresh counter and sticky overrun flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      refcnt_q  <= 11'd0;
      pending_q <= PEND_ZERO;
      overrun_q <= 1'b0;
    end else begin
      refcnt_q  <= refcnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Interval timer: loaded when leaving WAIT_INIT, ticks once every tim_refi cycles
  always_comb begin
    refcnt_d = refcnt_q;
    tick_s   = 1'b0;
    if (!sdram_initialized) begin
      refcnt_d = 11'd0;
    end else if (state_q == S_WAIT_INIT) begin
      refcnt_d = tim_refi - 11'd1;
    end else if (tim_refi != 11'd0) begin
      if (refcnt_q == 11'd0) begin
        refcnt_d = tim_refi - 11'd1;
        tick_s   = 1'b1;
      end else begin
        refcnt_d = refcnt_q - 11'd1;
      end
    end else begin
      refcnt_d = refcnt_q;
    end
  end

  // A tick and a refresh on the same edge cancel; a tick is lost only when nothing drains
  always_comb begin
    refresh_s = (state_q == S_REFRESH);
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (!sdram_initialized) begin
      pending_d = PEND_ZERO;
    end else if (tick_s && !refresh_s) begin
      if (pending_q == PEND_MAX) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (!tick_s && refresh_s) begin
      pending_d = pending_q - PEND_ONE;
    end else begin
      pending_d = pending_q;
    end
  end

  // Next-state logic: pending refreshes win over grants; an owner is never preempted
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    waitcnt_d = waitcnt_q;
    if (!sdram_initialized) begin
      state_d   = S_WAIT_INIT;
      waitcnt_d = 4'd0;
    end else begin
      case (state_q)
        S_WAIT_INIT: state_d = S_IDLE;
        S_IDLE: begin
          if (pending_q != PEND_ZERO) begin
            state_d = S_REFRESH;
          end else if (req0 && req1) begin
            state_d = last_q ? S_GRANT0 : S_GRANT1;
          end else if (req0) begin
            state_d = S_GRANT0;
          end else if (req1) begin
            state_d = S_GRANT1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GRANT0: begin
          if (rel0) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
          end else begin
            state_d = S_GRANT0;
          end
        end
        S_GRANT1: begin
          if (rel1) begin
            state_d = S_IDLE;
            last_d  = 1'b1;
          end else begin
            state_d = S_GRANT1;
          end
        end
        S_REFRESH: begin
          if (tim_rfc == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_REF_WAIT;
            waitcnt_d = tim_rfc;
          end
        end
        S_REF_WAIT: begin
          if (waitcnt_q <= 4'd1) begin
            state_d = S_IDLE;
          end else begin
            waitcnt_d = waitcnt_q - 4'd1;
          end
        end
        default: state_d = S_WAIT_INIT;
      endcase
    end
  end

  // Output decode of the next state, so each output flop mirrors the state register
  always_comb begin
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    ref_cmd_s = 1'b0;
    busy_s    = 1'b0;
    case (state_d)
      S_GRANT0: begin
        gnt0_s = 1'b1;
        busy_s = 1'b1;
      end
      S_GRANT1: begin
        gnt1_s = 1'b1;
        busy_s = 1'b1;
      end
      S_REFRESH: begin
        ref_cmd_s = 1'b1;
        busy_s    = 1'b1;
      end
      S_REF_WAIT: busy_s = 1'b1;
      S_IDLE, S_WAIT_INIT: busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign ref_cmd     = ref_cmd_q;
  assign busy        = busy_q;
  assign ref_overrun = overrun_q;

endmodule

// File: tb/tb_hpdmc_sched.sv
// tb_hpdmc_sched: directed and randomized checks of hpdmc_sched against a reference
// model that tracks bus ownership, refresh windows and tick times as cycle numbers.
module tb_hpdmc_sched;

  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sdram_initialized = 1'b0;
  logic [10:0] tim_refi = 11'd0;
  logic [3:0]  tim_rfc = 4'd0;
  logic        req0 = 1'b0, req1 = 1'b0, rel0 = 1'b0, rel1 = 1'b0;
  logic        gnt0, gnt1, ref_cmd, busy, ref_overrun;
  logic [4:0]  obs;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e_init = 0;

  // reference model: owner -1 means nobody; refresh window spans cycles [m_wstart, m_wend]
  bit m_up, m_win, m_ovr;
  int m_owner, m_last, m_pend, m_wstart, m_wend, m_tick_at;

  hpdmc_sched #(.PEND_W(PW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sdram_initialized(sdram_initialized),
    .tim_refi(tim_refi), .tim_rfc(tim_rfc),
    .req0(req0), .req1(req1), .rel0(rel0), .rel1(rel1),
    .gnt0(gnt0), .gnt1(gnt1), .ref_cmd(ref_cmd), .busy(busy), .ref_overrun(ref_overrun)
  );

  assign obs = {gnt0, gnt1, ref_cmd, busy, ref_overrun};

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_up = 1'b0; m_win = 1'b0; m_ovr = 1'b0;
    m_owner = -1; m_last = 1; m_pend = 0; m_wstart = -10; m_wend = -10; m_tick_at = -1;
  endtask

  // advance the model across the coming edge, using the inputs the DUT will sample there
  task automatic model_step();
    int  e;
    int  pend_old;
    bit  tick;
    bit  refdone;
    e = cyc + 1;
    if (!sdram_initialized) begin
      m_up = 1'b0; m_owner = -1; m_win = 1'b0; m_pend = 0; m_tick_at = -1;
      return;
    end
    if (!m_up) begin
      m_up = 1'b1;
      m_tick_at = (tim_refi != 11'd0) ? e + int'(tim_refi) : -1;
      return;
    end
    pend_old = m_pend;
    tick = (m_tick_at == e);
    if (tick) m_tick_at = e + int'(tim_refi);
    refdone = m_win && (e - 1 == m_wstart);
    if (tick && !refdone) begin
      if (m_pend == PMAX) m_ovr = 1'b1;
      else m_pend++;
    end else if (!tick && refdone) begin
      m_pend--;
    end
    if (m_owner == 0) begin
      if (rel0) begin m_owner = -1; m_last = 0; end
    end else if (m_owner == 1) begin
      if (rel1) begin m_owner = -1; m_last = 1; end
    end else if (m_win) begin
      if (e - 1 == m_wend) m_win = 1'b0;
    end else if (pend_old > 0) begin
      m_win = 1'b1; m_wstart = e; m_wend = e + int'(tim_rfc);
    end else if (req0 && req1) begin
      m_owner = (m_last == 0) ? 1 : 0;
    end else if (req0) begin
      m_owner = 0;
    end else if (req1) begin
      m_owner = 1;
    end
  endtask

  function automatic logic [4:0] m_exp();
    logic [4:0] v;
    v[4] = (m_owner == 0);
    v[3] = (m_owner == 1);
    v[2] = m_win && (cyc == m_wstart);
    v[1] = m_up && (m_owner >= 0 || m_win);
    v[0] = m_ovr;
    return v;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge sys_clk);
    #1;
    cyc++;
    rel0 = 1'b0;
    rel1 = 1'b0;
  endtask

  task automatic reinit(input int refi, input int rfc);
    sdram_initialized = 1'b0;
    cycle();
    tim_refi = 11'(refi);
    tim_rfc  = 4'(rfc);
    sdram_initialized = 1'b1;
    cycle();
    e_init = cyc;
  endtask

  task automatic rand_traffic();
    if ($urandom_range(0, 7) == 0) req0 = ~req0;
    if ($urandom_range(0, 7) == 0) req1 = ~req1;
    rel0 = ($urandom_range(0, 5) == 0);
    rel1 = ($urandom_range(0, 5) == 0);
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(posedge sys_clk); #1; cyc++;
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL reset_hold cyc=%0d got=%b want=00000", cyc, obs); end
    end
    sys_rst_n = 1'b1;
    reinit(740, 8);
    req0 = 1'b1;
    cycle();
    total++;
    if (obs !== 5'b10010) begin bad++; $display("FAIL reset_pregrant got=%b want=10010", obs); end
    #3 sys_rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL reset_async got=%b want=00000", obs); end
    repeat (2) begin
      @(posedge sys_clk); #1; cyc++;
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL reset_midgrant cyc=%0d got=%b want=00000", cyc, obs); end
    end
    req0 = 1'b0;
    sdram_initialized = 1'b0;
    model_reset();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_init_refresh();
    int first_ref = -1;
    int nref = 0;
    int busy_len = 0;
    reinit(740, 8);
    for (int i = 0; i < 760; i++) begin
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL init_model cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (ref_cmd) begin nref++; if (first_ref < 0) first_ref = cyc; end
      if (first_ref >= 0 && cyc <= first_ref + 12 && busy) busy_len++;
    end
    // the tick lands refi cycles after load and is acted on one cycle later
    total++;
    if (first_ref != e_init + 741) begin bad++; $display("FAIL init_first_ref got=%0d want=%0d", first_ref, e_init + 741); end
    total++;
    if (nref != 1) begin bad++; $display("FAIL init_ref_count got=%0d want=1", nref); end
    total++;
    if (busy_len != 9) begin bad++; $display("FAIL init_ref_window got=%0d want=9", busy_len); end
  endtask

  task automatic test_round_robin();
    int exp_port = 0;
    reinit(1500, 8);
    req0 = 1'b1; req1 = 1'b1;
    cycle();
    for (int g = 0; g < 4; g++) begin
      total++;
      if ({gnt0, gnt1} !== ((exp_port == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_grant n=%0d got=%b%b want_port=%0d", g, gnt0, gnt1, exp_port);
      end
      repeat (4) cycle();
      total++;
      if ({gnt0, gnt1} !== ((exp_port == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_hold n=%0d got=%b%b want_port=%0d", g, gnt0, gnt1, exp_port);
      end
      if (exp_port == 0) rel0 = 1'b1; else rel1 = 1'b1;
      if (g == 3) begin req0 = 1'b0; req1 = 1'b0; end
      cycle();
      total++;
      if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL rr_drop n=%0d got=%b%b want=00", g, gnt0, gnt1); end
      cycle();
      exp_port = 1 - exp_port;
    end
    total++;
    if (obs !== 5'b00000) begin bad++; $display("FAIL rr_end got=%b want=00000", obs); end
  endtask

  task automatic test_postpone();
    int k;
    int gnt1_at = -1;
    int refs[$];
    logic [1:0] exp_pend;
    reinit(740, 8);
    req0 = 1'b1;
    cycle();
    req1 = 1'b1;
    repeat (1999) begin
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL post_hold cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
    end
    exp_pend = 2'((cyc - e_init) / 740);
    total++;
    if (dut.pending_q !== exp_pend) begin bad++; $display("FAIL post_pending got=%0d want=%0d", dut.pending_q, exp_pend); end
    rel0 = 1'b1; req0 = 1'b0;
    cycle();
    k = cyc;
    for (int i = 0; i < 30; i++) begin
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL post_drain cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (ref_cmd) refs.push_back(cyc);
      if (gnt1 && gnt1_at < 0) gnt1_at = cyc;
    end
    total++;
    if (refs.size() != 2) begin
      bad++; $display("FAIL post_ref_count got=%0d want=2", refs.size());
    end else begin
      total++;
      if (refs[0] != k + 1 || refs[1] - refs[0] != 10) begin
        bad++; $display("FAIL post_ref_times got=%0d,%0d want=%0d,%0d", refs[0], refs[1], k + 1, k + 11);
      end
    end
    total++;
    if (gnt1_at != k + 21) begin bad++; $display("FAIL post_gnt1 got=%0d want=%0d", gnt1_at, k + 21); end
    rel1 = 1'b1; req1 = 1'b0;
    cycle();
  endtask

  task automatic test_overrun();
    int ovr_at = -1;
    int k;
    int nref = 0;
    int ref_first = -1;
    req0 = 1'b1;
    reinit(16, 8);
    repeat (80) begin
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL ovr_hold cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (ref_overrun && ovr_at < 0) ovr_at = cyc;
    end
    total++;
    if (ovr_at != e_init + 4 * 16) begin bad++; $display("FAIL ovr_set got=%0d want=%0d", ovr_at, e_init + 64); end
    rel0 = 1'b1; req0 = 1'b0;
    cycle();
    k = cyc;
    repeat (30) begin
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL ovr_drain cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (ref_cmd) begin nref++; if (ref_first < 0) ref_first = cyc; end
    end
    total++;
    if (nref != 3 || ref_first != k + 1) begin
      bad++; $display("FAIL ovr_refs got=%0d@%0d want=3@%0d", nref, ref_first, k + 1);
    end
    total++;
    if (ref_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", ref_overrun); end
  endtask

  task automatic test_boundaries();
    int refs[$];
    logic busy_after = 1'b1;
    int nref = 0;
    reinit(20, 0);
    repeat (45) begin
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL rfc0_model cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (ref_cmd) refs.push_back(cyc);
      if (cyc == e_init + 22) busy_after = busy;
    end
    total++;
    if (refs.size() != 2) begin
      bad++; $display("FAIL rfc0_ref_count got=%0d want=2", refs.size());
    end else begin
      total++;
      if (refs[0] != e_init + 21 || refs[1] != e_init + 41) begin
        bad++; $display("FAIL rfc0_ref_times got=%0d,%0d want=%0d,%0d", refs[0], refs[1], e_init + 21, e_init + 41);
      end
    end
    total++;
    if (busy_after !== 1'b0) begin bad++; $display("FAIL rfc0_idle got=%b want=0", busy_after); end
    reinit(0, 8);
    repeat (2100) begin
      rand_traffic();
      cycle();
      total++;
      if (obs !== m_exp()) begin bad++; $display("FAIL refi0_model cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      if (ref_cmd) nref++;
    end
    total++;
    if (nref != 0) begin bad++; $display("FAIL refi0_no_ref got=%0d want=0", nref); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_init_loss();
    reinit(30, 8);
    req1 = 1'b1;
    cycle();
    total++;
    if ({gnt0, gnt1, busy} !== 3'b011) begin bad++; $display("FAIL loss_grant got=%b%b%b want=011", gnt0, gnt1, busy); end
    while (cyc < e_init + 9) cycle();
    rel0 = 1'b1;
    cycle();
    total++;
    if ({gnt0, gnt1, busy} !== 3'b011) begin bad++; $display("FAIL loss_stray_rel got=%b%b%b want=011", gnt0, gnt1, busy); end
    while (cyc < e_init + 30) cycle();
    total++;
    if (dut.pending_q !== 2'd1) begin bad++; $display("FAIL loss_pending_before got=%0d want=1", dut.pending_q); end
    sdram_initialized = 1'b0;
    cycle();
    total++;
    if ({gnt1, busy, dut.pending_q} !== 4'b0000) begin
      bad++; $display("FAIL loss_drop got=gnt1:%b busy:%b pend:%0d want=0,0,0", gnt1, busy, dut.pending_q);
    end
    // leaving WAIT_INIT takes an edge, so the still-high req1 is granted one cycle later
    sdram_initialized = 1'b1;
    cycle();
    total++;
    if (gnt1 !== 1'b0) begin bad++; $display("FAIL loss_wait_init got=%b want=0", gnt1); end
    cycle();
    total++;
    if (gnt1 !== 1'b1) begin bad++; $display("FAIL loss_regrant got=%b want=1", gnt1); end
    rel1 = 1'b1; req1 = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1; cyc++;
    model_reset();
    sdram_initialized = 1'b0;
    sys_rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      reinit($urandom_range(12, 60), $urandom_range(0, 15));
      repeat (600) begin
        rand_traffic();
        if (sdram_initialized && $urandom_range(0, 299) == 0) sdram_initialized = 1'b0;
        else sdram_initialized = 1'b1;
        cycle();
        total++;
        if (obs !== m_exp()) begin bad++; $display("FAIL rand_model cyc=%0d got=%b want=%b", cyc, obs, m_exp()); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_refresh();
    test_round_robin();
    test_postpone();
    test_overrun();
    test_boundaries();
    test_init_loss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
